mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-master to one-slave arbiter on the memory bus, upstream of memory_async and downstream of the cpu's fetch and load/store paths. Instruction port (i_*) and data port (d_*) request independently. One transaction at a time is forwarded with registered address, data and control. Round-robin fairness, per-port completion pulse, and a watchdog against a slave that never acks.

Parameters:
WIDTH, `MEMORY_WIDTH, memory data bus width in bits (multiple of 8)
ADDR_WIDTH, 32, address width
TIMEOUT, 1024, BUSY cycles without mem_ack before the transaction is aborted (>=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
i_enable  in  1  instruction port request, held until i_ack
i_addr  in  ADDR_WIDTH  instruction address
i_data_out  out  WIDTH  instruction read data, held until next instruction read completes
i_ack  out  1  one-cycle completion pulse
d_enable  in  1  data port request, held until d_ack
d_rw  in  1  0 = read, 1 = write
d_addr  in  ADDR_WIDTH  data address
d_byte_enable  in  WIDTH/8  write byte lanes
d_data_in  in  WIDTH  write data
d_data_out  out  WIDTH  data read result, held until next data read completes
d_ack  out  1  one-cycle completion pulse
mem_enable  out  1  slave master_enable
mem_rw  out  1  slave read_write
mem_addr  out  ADDR_WIDTH  slave addr
mem_byte_enable  out  WIDTH/8  slave byte_enable; all ones for instruction reads
mem_data_in  out  WIDTH  slave data_in
mem_data_out  in  WIDTH  slave data_out
mem_ack  in  1  slave ack, level, stays high until mem_enable drops
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (reset low, any time, including mid-transaction): state IDLE. All outputs 0 (mem_enable, mem_rw, mem_addr, mem_byte_enable, mem_data_in, i/d_data_out, i/d_ack, timeout_err). Watchdog 0. last_grant = instruction, so the data port wins the first tie.
- States: IDLE, BUSY, RELEASE. Encoding is binary. Outputs are all registered.
- IDLE:
  - If any request is high at edge N, the winner is latched at edge N.
  - Forwarded outputs are valid and mem_enable = 1 in cycle N+1. State goes to BUSY and the watchdog clears.
  - The instruction port always drives rw = 0 and byte_enable all ones.
- Arbitration: single request wins. On a tie, the port not in last_grant wins. last_grant updates at every grant.
- BUSY:
  - Forwarded outputs are frozen; changes on the master inputs are ignored.
  - On mem_ack = 1 at an edge:
    - For a read, mem_data_out is captured into the owner's data_out.
    - The owner's ack pulses for exactly the next cycle.
    - mem_enable goes to 0 and the state moves to RELEASE.
  - Writes leave data_out unchanged.
- Watchdog: increments every BUSY cycle without ack. At the edge where it would reach TIMEOUT:
  - mem_enable goes to 0, timeout_err and the owner's ack pulse together, data_out is unchanged, and the state moves to RELEASE.
  - An ack arriving on that same edge takes precedence: normal completion, no error.
- RELEASE: stays until mem_ack is sampled 0, then IDLE. This guarantees the slave re-arms. New requests are ignored until IDLE.
- Masters drop or renew enable on the cycle after their ack. A request still high in IDLE is a new transaction.
- A master withdrawing enable mid-BUSY is illegal. The arbiter completes the transaction and still pulses ack.
- Minimum turnaround: grant, ack, release gives a gap of at least 1 cycle between transactions with the mem_enable=0 gap.
- i_ack and d_ack are never high together.

Decomposition:
- Shared header (already `included by cpu/memory): MEMORY_WIDTH, RW_READ/RW_WRITE constants, ARB state encodings.
- One sub-module: rr_arbiter2. Combinational two-request round-robin picker plus last_grant register; inputs req[1:0], grant_en; output grant one-hot.

Test Plan:
- Reset, then d_enable only, read addr 0x40, slave acks after 3 cycles with 0xDEAD... -> mem_addr=0x40, mem_rw=0, d_data_out=slave data, d_ack exactly 1 cycle, i_ack never high.
- i_enable and d_enable raised the same cycle after reset -> data granted first, instruction next. Then both held repeatedly -> grants strictly alternate I, D, I, D.
- d write, addr 0x80, byte_enable 0x000F, data 0x1234 -> mem_rw=1, mem_byte_enable=0x000F forwarded; d_data_out keeps its previous value; d_ack pulse.
- Slave never acks, TIMEOUT=8 -> timeout_err and owner ack pulse together after 8 BUSY cycles; mem_enable=0; with ack low, next IDLE grant proceeds.
- Slave holds ack high 5 cycles after enable drops -> arbiter stays in RELEASE; no new mem_enable until ack is 0.
- Assert reset low mid-BUSY -> all outputs 0 immediately (asynchronously); after release, first tie goes to the data port.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encodings for the two-master memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned MEMORY_WIDTH = 32;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Request/grant bit positions
  localparam int unsigned PORT_I = 0;
  localparam int unsigned PORT_D = 1;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbBusy    = 2'd1,
    ArbRelease = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-request round-robin picker. Grant is combinational; the last winner
// is remembered so that a tie goes to the other port.
module mem_arbiter_rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic last_d_q;  // 1 when the data port held the previous grant

  // Single request wins outright; a tie goes to the port not granted last
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_d_q ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner of every accepted grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d_q <= 1'b0;
    end else if (grant_en && (req != 2'b00)) begin
      last_d_q <= grant[PORT_D];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data to single-slave memory arbiter with registered forwarding,
// round-robin fairness, per-port completion pulse and a no-ack watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = MEMORY_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0]      i_data_out,
  output logic                  i_ack,
  input  logic                  d_enable,
  input  logic                  d_rw,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH/8-1:0]    d_byte_enable,
  input  logic [WIDTH-1:0]      d_data_in,
  output logic [WIDTH-1:0]      d_data_out,
  output logic                  d_ack,
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH/8-1:0]    mem_byte_enable,
  output logic [WIDTH-1:0]      mem_data_in,
  input  logic [WIDTH-1:0]      mem_data_out,
  input  logic                  mem_ack,
  output logic                  timeout_err
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  typedef logic [WdW-1:0] wd_t;
  localparam wd_t WdLast = wd_t'(TIMEOUT - 1);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;  // 1 = data port owns the bus
  wd_t        wdog_q, wdog_d;
  logic [1:0] req, grant;
  logic       grant_en, wd_expire;

  logic                  mem_enable_d, mem_rw_d, i_ack_d, d_ack_d, timeout_err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [WIDTH/8-1:0]    mem_byte_enable_d;
  logic [WIDTH-1:0]      mem_data_in_d, i_data_out_d, d_data_out_d;

  assign req       = {d_enable, i_enable};
  assign grant_en  = (state_q == ArbIdle);
  // Asserted on the BUSY cycle whose un-acked edge would reach TIMEOUT
  assign wd_expire = (wdog_q == WdLast);

  mem_arbiter_rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant_en (grant_en),
    .grant    (grant)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ArbIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant from IDLE, finish on ack or watchdog, drain until ack drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      ArbIdle:    if (req != 2'b00) state_d = ArbBusy;
      ArbBusy:    if (mem_ack || wd_expire) state_d = ArbRelease;
      ArbRelease: if (!mem_ack) state_d = ArbIdle;
      default:    state_d = ArbIdle;
    endcase
  end

  // Next values of the registered outputs, owner and watchdog
  always_comb begin
    owner_d           = owner_q;
    wdog_d            = wdog_q;
    mem_enable_d      = mem_enable;
    mem_rw_d          = mem_rw;
    mem_addr_d        = mem_addr;
    mem_byte_enable_d = mem_byte_enable;
    mem_data_in_d     = mem_data_in;
    i_data_out_d      = i_data_out;
    d_data_out_d      = d_data_out;
    i_ack_d           = 1'b0;
    d_ack_d           = 1'b0;
    timeout_err_d     = 1'b0;
    case (state_q)
      ArbIdle: begin
        if (grant[PORT_D]) begin
          owner_d           = 1'b1;
          wdog_d            = '0;
          mem_enable_d      = 1'b1;
          mem_rw_d          = d_rw ? RW_WRITE : RW_READ;
          mem_addr_d        = d_addr;
          mem_byte_enable_d = d_byte_enable;
          mem_data_in_d     = d_data_in;
        end else if (grant[PORT_I]) begin
          owner_d           = 1'b0;
          wdog_d            = '0;
          mem_enable_d      = 1'b1;
          mem_rw_d          = RW_READ;
          mem_addr_d        = i_addr;
          mem_byte_enable_d = '1;
          mem_data_in_d     = '0;
        end
      end
      ArbBusy: begin
        // An ack on the expiry edge still counts as a normal completion
        if (mem_ack) begin
          mem_enable_d = 1'b0;
          i_ack_d      = ~owner_q;
          d_ack_d      = owner_q;
          if (mem_rw == RW_READ) begin
            if (owner_q) d_data_out_d = mem_data_out;
            else         i_data_out_d = mem_data_out;
          end
        end else if (wd_expire) begin
          mem_enable_d  = 1'b0;
          timeout_err_d = 1'b1;
          i_ack_d       = ~owner_q;
          d_ack_d       = owner_q;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output, owner and watchdog registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q         <= 1'b0;
      wdog_q          <= '0;
      mem_enable      <= 1'b0;
      mem_rw          <= 1'b0;
      mem_addr        <= '0;
      mem_byte_enable <= '0;
      mem_data_in     <= '0;
      i_data_out      <= '0;
      d_data_out      <= '0;
      i_ack           <= 1'b0;
      d_ack           <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      owner_q         <= owner_d;
      wdog_q          <= wdog_d;
      mem_enable      <= mem_enable_d;
      mem_rw          <= mem_rw_d;
      mem_addr        <= mem_addr_d;
      mem_byte_enable <= mem_byte_enable_d;
      mem_data_in     <= mem_data_in_d;
      i_data_out      <= i_data_out_d;
      d_data_out      <= d_data_out_d;
      i_ack           <= i_ack_d;
      d_ack           <= d_ack_d;
      timeout_err     <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, tie/alternation
// and reset sequences, then randomized traffic against a transaction model.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int AW = 32;
  localparam int BW = W / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_enable, i_ack, d_enable, d_rw, d_ack;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [W-1:0]  i_data_out, d_data_in, d_data_out, mem_data_in, mem_data_out;
  logic [BW-1:0] d_byte_enable, mem_byte_enable;
  logic          mem_enable, mem_rw, mem_ack, timeout_err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_enable        (i_enable),
    .i_addr          (i_addr),
    .i_data_out      (i_data_out),
    .i_ack           (i_ack),
    .d_enable        (d_enable),
    .d_rw            (d_rw),
    .d_addr          (d_addr),
    .d_byte_enable   (d_byte_enable),
    .d_data_in       (d_data_in),
    .d_data_out      (d_data_out),
    .d_ack           (d_ack),
    .mem_enable      (mem_enable),
    .mem_rw          (mem_rw),
    .mem_addr        (mem_addr),
    .mem_byte_enable (mem_byte_enable),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out),
    .mem_ack         (mem_ack),
    .timeout_err     (timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_enable = 0; i_addr = '0;
    d_enable = 0; d_rw = 0; d_addr = '0; d_byte_enable = '0; d_data_in = '0;
    mem_ack = 0; mem_data_out = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_enable"}, mem_enable, 0);
    chk({tag, "_mem_rw"}, mem_rw, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_be"}, mem_byte_enable, 0);
    chk({tag, "_mem_data_in"}, mem_data_in, 0);
    chk({tag, "_i_data_out"}, i_data_out, 0);
    chk({tag, "_d_data_out"}, d_data_out, 0);
    chk({tag, "_acks"}, {i_ack, d_ack}, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1;
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            is_d;
    bit            rw;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [W-1:0]  wdata;
    int            delay;     // slave raises ack on busy cycle delay+1
    int            hold;      // extra cycles ack stays high after enable drops
    logic [W-1:0]  rdata;
    bit            exp_rw;
    logic [BW-1:0] exp_be;
    int            exp_busy;  // cycles mem_enable is high
    bit            exp_to;
    logic [W-1:0]  exp_dout;  // owner's data_out after completion
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int k, input vec_t v);
    int busy = 0;
    bit done = 0;
    @(negedge clk);
    mem_data_out = v.rdata;
    if (v.is_d) begin
      d_enable = 1; d_rw = v.rw; d_addr = v.addr; d_byte_enable = v.be; d_data_in = v.wdata;
    end else begin
      i_enable = 1; i_addr = v.addr;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_enable) begin
        if (busy == 0) begin
          chk($sformatf("v%0d_mem_addr", k), mem_addr, v.addr);
          chk($sformatf("v%0d_mem_rw", k), mem_rw, v.exp_rw);
          chk($sformatf("v%0d_mem_be", k), mem_byte_enable, v.exp_be);
          if (v.is_d && v.rw) chk($sformatf("v%0d_mem_data_in", k), mem_data_in, v.wdata);
        end
        chk($sformatf("v%0d_busy_acks", k), {i_ack, d_ack, timeout_err}, 0);
        busy++;
        if (busy > v.delay) mem_ack = 1;
      end else if (i_ack || d_ack) begin
        done = 1;
        chk($sformatf("v%0d_busy_cycles", k), busy, v.exp_busy);
        chk($sformatf("v%0d_owner_ack", k), v.is_d ? d_ack : i_ack, 1);
        chk($sformatf("v%0d_other_ack", k), v.is_d ? i_ack : d_ack, 0);
        chk($sformatf("v%0d_timeout_err", k), timeout_err, v.exp_to);
        chk($sformatf("v%0d_data_out", k), v.is_d ? d_data_out : i_data_out, v.exp_dout);
      end
    end
    chk($sformatf("v%0d_done", k), done, 1);
    if (v.hold > 0) begin
      // Master renews at once; the slave keeps ack high, so no new grant yet
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        chk($sformatf("v%0d_hold_en", k), mem_enable, 0);
        chk($sformatf("v%0d_hold_ack", k), {i_ack, d_ack}, 0);
      end
      mem_ack = 0;
      @(negedge clk);
      chk($sformatf("v%0d_rearm_en", k), mem_enable, 0);
      @(negedge clk);
      chk($sformatf("v%0d_regrant_en", k), mem_enable, 1);
      chk($sformatf("v%0d_regrant_addr", k), mem_addr, v.addr);
      mem_ack = 1;
      @(negedge clk);
      chk($sformatf("v%0d_regrant_ack", k), v.is_d ? d_ack : i_ack, 1);
      i_enable = 0; d_enable = 0; mem_ack = 0;
      @(negedge clk);
    end else begin
      i_enable = 0; d_enable = 0; mem_ack = 0;
      @(negedge clk);
      chk($sformatf("v%0d_ack_one_cycle", k), {i_ack, d_ack, timeout_err}, 0);
    end
  endtask

  // Both ports request continuously; grants must start with data and alternate
  task automatic tie_seq(input string tag, input int n);
    logic [AW-1:0] seen[$];
    int got = 0;
    @(negedge clk);
    mem_data_out = '0;
    i_enable = 1; i_addr = 32'h1000;
    d_enable = 1; d_rw = 0; d_addr = 32'h2000; d_byte_enable = '1;
    for (int c = 0; c < 20 * n && got < n; c++) begin
      @(negedge clk);
      chk({tag, "_acks_exclusive"}, i_ack & d_ack, 0);
      if (mem_enable && !mem_ack) begin
        seen.push_back(mem_addr);
        mem_ack = 1;
      end else if (i_ack || d_ack) begin
        got++;
        mem_ack = 0;
        if (got == n) begin i_enable = 0; d_enable = 0; end
      end
    end
    chk({tag, "_done"}, got, n);
    chk({tag, "_count"}, seen.size(), n);
    for (int i = 0; i < seen.size(); i++)
      chk($sformatf("%s_grant%0d", tag, i), seen[i], (i % 2 == 0) ? 32'h2000 : 32'h1000);
    @(negedge clk);
  endtask

  // ---------------- randomized traffic model ----------------
  bit            m_busy, m_drain, m_own_d, m_last_d, m_rw;
  int            m_wait;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic [W-1:0]  m_wdata, m_idout, m_ddout;
  bit            e_iack, e_dack, e_to;
  int            s_cnt, s_delay, s_hold;

  // Predict what the next clock edge does, given the inputs now applied
  task automatic model_step();
    e_iack = 0; e_dack = 0; e_to = 0;
    if (m_busy) begin
      if (mem_ack || m_wait + 1 == TO) begin
        m_busy = 0; m_drain = 1;
        if (m_own_d) e_dack = 1; else e_iack = 1;
        if (mem_ack) begin
          if (!m_rw) begin
            if (m_own_d) m_ddout = mem_data_out; else m_idout = mem_data_out;
          end
        end else begin
          e_to = 1;
        end
      end else begin
        m_wait++;
      end
    end else if (m_drain) begin
      if (!mem_ack) m_drain = 0;
    end else if (i_enable || d_enable) begin
      m_own_d  = (i_enable && d_enable) ? !m_last_d : d_enable;
      m_last_d = m_own_d;
      m_busy = 1; m_wait = 0;
      m_addr  = m_own_d ? d_addr : i_addr;
      m_rw    = m_own_d ? d_rw : 1'b0;
      m_be    = m_own_d ? d_byte_enable : '1;
      m_wdata = d_data_in;
    end
  endtask

  task automatic random_phase(input int cycles);
    m_busy = 0; m_drain = 0; m_own_d = 0; m_last_d = 0; m_rw = 0; m_wait = 0;
    m_addr = '0; m_be = '0; m_wdata = '0; m_idout = '0; m_ddout = '0;
    s_cnt = 0; s_delay = $urandom_range(0, 9); s_hold = $urandom_range(0, 2);
    model_step();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clk);
      chk("rnd_mem_enable", mem_enable, m_busy);
      if (m_busy) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_rw", mem_rw, m_rw);
        chk("rnd_mem_be", mem_byte_enable, m_be);
        if (m_own_d && m_rw) chk("rnd_mem_data_in", mem_data_in, m_wdata);
      end
      chk("rnd_i_ack", i_ack, e_iack);
      chk("rnd_d_ack", d_ack, e_dack);
      chk("rnd_timeout_err", timeout_err, e_to);
      chk("rnd_i_data_out", i_data_out, m_idout);
      chk("rnd_d_data_out", d_data_out, m_ddout);
      // Masters may only change their request when idle or just acked
      if (i_ack || !i_enable) begin
        i_enable = ($urandom_range(0, 2) != 0);
        i_addr   = $urandom;
      end
      if (d_ack || !d_enable) begin
        d_enable      = ($urandom_range(0, 2) != 0);
        d_rw          = $urandom_range(0, 1);
        d_addr        = $urandom;
        d_byte_enable = $urandom;
        d_data_in     = $urandom;
      end
      // Slave: level ack after a random latency, optional lingering ack
      if (mem_enable) begin
        s_cnt++;
        if (s_cnt > s_delay) mem_ack = 1;
      end else begin
        s_cnt = 0;
        if (mem_ack) begin
          if (s_hold > 0) s_hold--;
          else mem_ack = 0;
        end else begin
          s_delay = $urandom_range(0, 9);
          s_hold  = $urandom_range(0, 2);
        end
      end
      mem_data_out = $urandom;
      model_step();
    end
    i_enable = 0; d_enable = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h40,  4'h5, 32'h0,    3,   0, 32'hDEADBEEF,
                1'b0, 4'h5, 4, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h80,  4'h3, 32'h1234, 1,   0, 32'hFFFFFFFF,
                1'b1, 4'h3, 2, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h100, 4'h0, 32'h0,    0,   0, 32'h13,
                1'b0, 4'hF, 1, 1'b0, 32'h13};
    vecs[3] = '{1'b1, 1'b0, 32'h44,  4'hC, 32'h0,    2,   5, 32'hCAFEF00D,
                1'b0, 4'hC, 3, 1'b0, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 32'h200, 4'h0, 32'h0,    100, 0, 32'h77,
                1'b0, 4'hF, 8, 1'b1, 32'h13};
    vecs[5] = '{1'b1, 1'b0, 32'h48,  4'hF, 32'h0,    100, 0, 32'h99,
                1'b0, 4'hF, 8, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b0, 32'h204, 4'h0, 32'h0,    7,   0, 32'h55,
                1'b0, 4'hF, 8, 1'b0, 32'h55};

    do_reset();
    tie_seq("tie", 5);

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Reset in the middle of a transaction clears outputs without a clock
    @(negedge clk);
    d_enable = 1; d_rw = 0; d_addr = 32'h300; d_byte_enable = '1; mem_ack = 0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", mem_enable, 1);
    #2 reset = 0;
    #1 chk_zero("async_reset");
    idle_inputs();
    @(negedge clk);
    reset = 1;
    tie_seq("post_reset_tie", 2);

    do_reset();
    random_phase(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
